// File: rtl/game_flow_sequencer.sv
// Top-level game-flow controller: sequences levels, tracks lives, times the respawn
// screen and keeps every inactive level module held in reset.
module game_flow_sequencer #(
    parameter int NUM_LEVELS     = 3,
    parameter int LVL_W          = 3,
    parameter int START_LIVES    = 3,
    parameter int LIVES_W        = 3,
    parameter int RESPAWN_CYCLES = 25_000_000,
    parameter int CNT_W          = 25
) (
    input  logic                  vga_clock,
    input  logic                  reset,
    input  logic                  start_button,
    input  logic [NUM_LEVELS-1:0] level_win,
    input  logic [NUM_LEVELS-1:0] level_lose,
    input  logic                  finish_done,
    output logic [2:0]            screen,
    output logic [LVL_W-1:0]      level_num,
    output logic [NUM_LEVELS-1:0] level_rst_n,
    output logic [LIVES_W-1:0]    lives,
    output logic                  show_hearts
);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_RESPAWN   = 3'd1,
        ST_PLAY      = 3'd2,
        ST_FINISH    = 3'd3,
        ST_WIN       = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_e;

    localparam logic [LVL_W-1:0]   LAST_LEVEL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(START_LIVES);
    localparam logic [CNT_W-1:0]   RESPAWN_INIT = CNT_W'(RESPAWN_CYCLES - 1);

    state_e               state_q, state_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic                 btn_now_q, btn_prev_q, btn_arm_q;
    logic                 press;
    logic [NUM_LEVELS-1:0] level_sel;
    logic                 win_cur, lose_cur;

    // The arm bit stays clear until the button has been seen released, so a
    // button held down across reset release never counts as a press.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            btn_now_q  <= 1'b1;
            btn_prev_q <= 1'b1;
            btn_arm_q  <= 1'b0;
        end else begin
            btn_now_q  <= start_button;
            btn_prev_q <= btn_now_q;
            btn_arm_q  <= btn_arm_q | start_button;
        end
    end

    assign press = btn_arm_q & btn_prev_q & ~btn_now_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
            assign level_sel[gi]   = (level_q == LVL_W'(gi));
            assign level_rst_n[gi] = level_sel[gi] && (state_q == ST_PLAY);
        end
    endgenerate

    assign win_cur  = |(level_win & level_sel);
    assign lose_cur = |(level_lose & level_sel);

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_START;
            level_q <= '0;
            lives_q <= LIVES_INIT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        timer_d = timer_q;
        case (state_q)
            ST_START: begin
                if (press) begin
                    state_d = ST_PLAY;
                    level_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            ST_RESPAWN: begin
                if (timer_q == '0 || press) begin
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_PLAY: begin
                // Lose outranks win when both arrive together.
                if (lose_cur) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_RESPAWN;
                        timer_d = RESPAWN_INIT;
                    end else begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end
                end else if (win_cur) begin
                    if (level_q < LAST_LEVEL) begin
                        level_d = level_q + LVL_W'(1);
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                if (finish_done) begin
                    state_d = ST_WIN;
                end
            end
            ST_WIN, ST_GAME_OVER: begin
                if (press) begin
                    state_d = ST_START;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    assign screen      = state_q;
    assign level_num   = level_q;
    assign lives       = lives_q;
    assign show_hearts = (state_q == ST_RESPAWN) || (state_q == ST_PLAY) ||
                         (state_q == ST_FINISH);

endmodule
